// File: rtl/multiplier_21bits.sv
// Sequential signed fixed-point multiplier using radix-2 shift-add on magnitudes, then sign fix-up and rescale.
// Optional build macro MULT_SAT_EN: clamp product on overflow instead of wrapping.
module multiplier_21bits #(
    parameter int WIDTH = 21,
    parameter int FRAC  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    open,
    input  logic signed [WIDTH-1:0] multiplicand,
    input  logic signed [WIDTH-1:0] multiplier,
    output logic                    finish,
    output logic signed [WIDTH-1:0] product,
    output logic                    ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [AW-1:0] POS_LIM = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] NEG_LIM = POS_LIM + 1'b1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        maga, magb;
    logic                    sign;
    logic [AW-1:0]           acc;
    logic [CW-1:0]           count;
    logic [AW-1:0]           mag_fix;
    logic [WIDTH-1:0]        mag_low;
    logic signed [WIDTH-1:0] res_w, res_out, res_p1;
    logic                    over, ovf_p1, vld_p1;

    // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(~v + 1'b1) : WIDTH'(v);
    endfunction

`ifdef MULT_SAT_EN
    function automatic logic signed [WIDTH-1:0] sat_fix(input logic signed [WIDTH-1:0] wrapped,
                                                        input logic neg, input logic over_in);
        if (over_in)
            return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return wrapped;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (open) state_nxt = CALC;
            CALC:    if (count == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (!vld_p1 && !open) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Rescale and sign fix-up, registered into the _p1 stage during FIX.
    always_comb begin
        mag_fix = acc >> FRAC;
        mag_low = mag_fix[WIDTH-1:0];
        res_w   = sign ? -mag_low : mag_low;
        over    = sign ? (mag_fix > NEG_LIM) : (mag_fix > POS_LIM);
`ifdef MULT_SAT_EN
        res_out = sat_fix(res_w, sign, over);
`else
        res_out = res_w;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            maga    <= '0;
            magb    <= '0;
            sign    <= 1'b0;
            acc     <= '0;
            count   <= '0;
            res_p1  <= '0;
            ovf_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
            finish  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (open) begin
                    maga  <= mag_of(multiplicand);
                    magb  <= mag_of(multiplier);
                    sign  <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                    acc   <= '0;
                    count <= '0;
                end
                CALC: begin
                    if (magb[count]) acc <= acc + (AW'(maga) << count);
                    count <= count + 1'b1;
                end
                FIX: begin
                    res_p1 <= res_out;
                    ovf_p1 <= over;
                    vld_p1 <= 1'b1;
                end
                // Output stage: publish once, then finish follows the open level.
                DONE: begin
                    if (vld_p1) begin
                        product <= res_p1;
                        ovf     <= ovf_p1;
                        finish  <= 1'b1;
                        vld_p1  <= 1'b0;
                    end else if (!open) begin
                        finish  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_21bits.sv
// Bench for multiplier_21bits: integer-arithmetic reference model, per-cycle output monitor, directed vectors.
module tb_multiplier_21bits;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic         open_v [2];
    logic [W-1:0] a_v    [2];
    logic [W-1:0] b_v    [2];
    logic         fin    [2];
    logic [W-1:0] prod   [2];
    logic         ov     [2];

    logic [W-1:0] exp_p  [2];
    logic         exp_o  [2];
    int           t0     [2];
    logic         prevfin[2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiplier_21bits #(.WIDTH(W), .FRAC(0)) u0 (
        .clk(clk), .rst(rst), .open(open_v[0]), .multiplicand(a_v[0]), .multiplier(b_v[0]),
        .finish(fin[0]), .product(prod[0]), .ovf(ov[0]));

    multiplier_21bits #(.WIDTH(W), .FRAC(8)) u1 (
        .clk(clk), .rst(rst), .open(open_v[1]), .multiplicand(a_v[1]), .multiplier(b_v[1]),
        .finish(fin[1]), .product(prod[1]), .ovf(ov[1]));

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Returns {ovf, product} from exact integer multiplication.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input int frac);
        longint full, mag, res;
        logic   o;
        logic [W-1:0] p;
        full = longint'($signed(a)) * longint'($signed(b));
        mag  = (full < 0 ? -full : full) >> frac;
        res  = (full < 0) ? -mag : mag;
        o    = (res > 64'sd1048575) || (res < -64'sd1048576);
        p    = res[W-1:0];
`ifdef MULT_SAT_EN
        if (o) p = (res > 0) ? 21'h0FFFFF : 21'h100000;
`endif
        return {o, p};
    endfunction

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst) begin
                if (fin[u] && !prevfin[u]) begin
                    chk("latency", cyc - t0[u], 23);
                    chk("model_product", prod[u], exp_p[u]);
                    chk("model_ovf", ov[u], exp_o[u]);
                end else if (fin[u]) begin
                    chk("held_product", prod[u], exp_p[u]);
                    chk("held_ovf", ov[u], exp_o[u]);
                end
            end
            prevfin[u] = fin[u];
        end
    end

    task automatic op(input int u, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      input logic [W-1:0] lp, input logic lo);
        int k, fallk;
        bit seen;
        logic [W:0] m;
        @(negedge clk);
        m        = model(a, b, (u == 0) ? 0 : 8);
        exp_p[u] = m[W-1:0];
        exp_o[u] = m[W];
        a_v[u]   = a;
        b_v[u]   = b;
        open_v[u] = 1'b1;
        @(posedge clk); #1;
        t0[u] = cyc;
        seen  = 0;
        fallk = (hold > 24) ? hold : 24;
        while (1) begin
            @(negedge clk);
            k = cyc - t0[u];
            if (k >= hold - 1) open_v[u] = 1'b0;
            else begin
                a_v[u] = W'($urandom);
                b_v[u] = W'($urandom);
            end
            if (fin[u] && !seen) begin
                seen = 1;
                chk("lit_product", prod[u], lp);
                chk("lit_ovf", ov[u], lo);
            end
            if (seen && !fin[u]) begin
                chk("finish_fall_edge", k, fallk);
                break;
            end
            if (k > 80) begin
                chk("finish_timeout", k, fallk);
                break;
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("idle_finish", fin[u], 0);
            chk("idle_product", prod[u], exp_p[u]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            open_v[u] = 1'b0; a_v[u] = '0; b_v[u] = '0; prevfin[u] = 1'b0;
            exp_p[u] = '0; exp_o[u] = 1'b0; t0[u] = 0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_finish", fin[u], 0);
            chk("reset_product", prod[u], 0);
            chk("reset_ovf", ov[u], 0);
        end
        rst = 1'b0;

        op(0, 21'd3, 21'h1FFFFB, 30, 21'h1FFFF1, 1'b0);
`ifdef MULT_SAT_EN
        op(0, 21'h100000, 21'h1FFFFF, 1, 21'h0FFFFF, 1'b1);
        op(0, 21'h100000, 21'h100000, 1, 21'h0FFFFF, 1'b1);
`else
        op(0, 21'h100000, 21'h1FFFFF, 1, 21'h100000, 1'b1);
        op(0, 21'h100000, 21'h100000, 1, 21'h000000, 1'b1);
`endif
        op(1, 21'h000180, 21'h000200, 5, 21'h000300, 1'b0);
        op(1, 21'h1FFEFF, 21'h000001, 1, 21'h1FFFFF, 1'b0);
        op(1, 21'h100000, 21'h000001, 26, 21'h1FF000, 1'b0);
        op(0, 21'd0, 21'h1ABCDE, 3, 21'd0, 1'b0);
        op(0, 21'd7, 21'd6, 1, 21'd42, 1'b0);
`ifdef MULT_SAT_EN
        op(0, 21'h0FFFFF, 21'h0FFFFF, 25, 21'h0FFFFF, 1'b1);
`else
        op(0, 21'h0FFFFF, 21'h0FFFFF, 25, 21'h000001, 1'b1);
`endif

        // Abort an operation mid-CALC.
        @(negedge clk);
        a_v[0] = 21'd5; b_v[0] = 21'd5; open_v[0] = 1'b1;
        repeat (11) @(negedge clk);
        open_v[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_finish", fin[0], 0);
        chk("abort_product", prod[0], 0);
        chk("abort_ovf", ov[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk("abort_no_finish", fin[0], 0);
        end
        op(0, 21'd2, 21'd2, 1, 21'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
